// File: rtl/uart_spi_cmd_sched_if.sv
// uart_spi_cmd_sched_if
//   Bundles the UART-receiver side, SPI-master side and status signals of
//   uart_spi_cmd_sched. Signal names keep their original i_/o_ prefixes,
//   which are seen from the scheduler's point of view.
//   slave  : used by the scheduler (drives o_*, reads i_*)
//   master : used by the environment (drives i_*, reads o_*)
//   Signals:
//     i_rx_data/i_rx_done/i_rx_parity_ok  received byte, strobe, parity status
//     o_spi_cs_n/o_spi_start/o_spi_data   SPI chip select, start strobe, byte
//     i_spi_busy/i_spi_done               SPI master status
//     o_busy/o_frame_ok/o_frame_err       scheduler status and frame pulses
//     o_err_code/o_overrun                last error code, dropped-byte pulse
interface uart_spi_cmd_sched_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] i_rx_data;
    logic                  i_rx_done;
    logic                  i_rx_parity_ok;
    logic                  o_spi_cs_n;
    logic                  o_spi_start;
    logic [DATA_WIDTH-1:0] o_spi_data;
    logic                  i_spi_busy;
    logic                  i_spi_done;
    logic                  o_busy;
    logic                  o_frame_ok;
    logic                  o_frame_err;
    logic [1:0]            o_err_code;
    logic                  o_overrun;

    modport slave (
        input  i_rx_data, i_rx_done, i_rx_parity_ok, i_spi_busy, i_spi_done,
        output o_spi_cs_n, o_spi_start, o_spi_data, o_busy, o_frame_ok,
               o_frame_err, o_err_code, o_overrun
    );

    modport master (
        output i_rx_data, i_rx_done, i_rx_parity_ok, i_spi_busy, i_spi_done,
        input  o_spi_cs_n, o_spi_start, o_spi_data, o_busy, o_frame_ok,
               o_frame_err, o_err_code, o_overrun
    );
endinterface

// File: rtl/uart_spi_cmd_sched.sv
// uart_spi_cmd_sched
//   Parses framed command bytes from a UART receiver (HEADER, LEN, LEN
//   payload bytes, optional CHK), buffers the payload and, once the frame
//   validates, streams it byte by byte into an SPI master inside a single
//   chip-select window. Reports frame completion / discard, the last error
//   code, and bytes dropped while a transfer is in progress.
//   Ports:
//     i_clk_sys  system clock
//     i_rst_n    asynchronous reset, active low
//     bus        uart_spi_cmd_sched_if.slave (UART rx, SPI master, status)
//   Error codes: 1 inter-byte timeout, 2 bad LEN, 3 checksum or parity.
//   Build option: define UART_CMD_CHK_EN to require and check the XOR
//   checksum byte (LEN ^ payload bytes). Without it the frame ends with the
//   last payload byte and error code 3 only reports parity failures.
module uart_spi_cmd_sched #(
    parameter int unsigned           DATA_WIDTH  = 8,
    parameter int unsigned           MAX_LEN     = 16,
    parameter logic [DATA_WIDTH-1:0] HEADER      = 8'hA5,
    parameter int unsigned           TIMEOUT_CYC = 50000,
    parameter int unsigned           CS_SETUP    = 4
) (
    input  logic                 i_clk_sys,
    input  logic                 i_rst_n,
    uart_spi_cmd_sched_if.slave  bus
);
    localparam int unsigned PTR_W = $clog2(MAX_LEN + 1);
    localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned CS_W  = (CS_SETUP > 1) ? $clog2(CS_SETUP) : 1;

    localparam logic [TMO_W-1:0]      TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [CS_W-1:0]       CS_LAST  = CS_W'(CS_SETUP - 1);
    localparam logic [DATA_WIDTH-1:0] LEN_MAX  = DATA_WIDTH'(MAX_LEN);

    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_LEN     = 2'd2;
    localparam logic [1:0] ERR_CHK     = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_PAYLOAD,
        ST_CHK,
        ST_CS_LEAD,
        ST_SEND,
        ST_WAIT,
        ST_CS_TRAIL
    } state_e;

    state_e                state_q, state_d;
    logic [PTR_W-1:0]      len_q, len_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic [CS_W-1:0]       cs_cnt_q, cs_cnt_d;
    logic                  cs_n_q, cs_n_d;
    logic                  spi_start_q, spi_start_d;
    logic [DATA_WIDTH-1:0] spi_data_q, spi_data_d;
    logic                  frame_ok_q, frame_ok_d;
    logic                  frame_err_q, frame_err_d;
    logic [1:0]            err_code_q, err_code_d;
    logic                  overrun_q, overrun_d;
    logic [DATA_WIDTH-1:0] mem_q [MAX_LEN];
    logic [DATA_WIDTH-1:0] mem_d [MAX_LEN];
`ifdef UART_CMD_CHK_EN
    logic [DATA_WIDTH-1:0] chk_q, chk_d;
`endif

    logic       in_frame;
    logic       in_xfer;
    logic       cs_cnt_done;
    logic       issue_send;
    logic       err_raise;
    logic [1:0] err_val;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        tmo_d       = '0;
        cs_cnt_d    = cs_cnt_q;
        cs_n_d      = cs_n_q;
        spi_start_d = 1'b0;
        spi_data_d  = spi_data_q;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        err_code_d  = err_code_q;
        overrun_d   = 1'b0;
        mem_d       = mem_q;
`ifdef UART_CMD_CHK_EN
        chk_d       = chk_q;
`endif
        issue_send  = 1'b0;
        err_raise   = 1'b0;
        err_val     = err_code_q;

        in_frame    = (state_q == ST_LEN) || (state_q == ST_PAYLOAD) || (state_q == ST_CHK);
        in_xfer     = (state_q == ST_CS_LEAD) || (state_q == ST_SEND) ||
                      (state_q == ST_WAIT) || (state_q == ST_CS_TRAIL);
        cs_cnt_done = (cs_cnt_q == CS_LAST);

        // Inter-byte timer only runs between bytes of a frame being received.
        if (in_frame && !bus.i_rx_done) begin
            tmo_d = tmo_q + TMO_W'(1);
        end

        if (in_xfer && bus.i_rx_done) begin
            overrun_d = 1'b1;
        end

        if (in_frame) begin
            if (bus.i_rx_done && !bus.i_rx_parity_ok) begin
                err_raise = 1'b1;
                err_val   = ERR_CHK;
            end else if (!bus.i_rx_done && (tmo_q == TMO_LAST)) begin
                err_raise = 1'b1;
                err_val   = ERR_TIMEOUT;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.i_rx_done && (bus.i_rx_data == HEADER)) begin
                    state_d  = ST_LEN;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                end
            end
            ST_LEN: begin
                if (bus.i_rx_done && !err_raise) begin
                    if ((bus.i_rx_data == '0) || (bus.i_rx_data > LEN_MAX)) begin
                        err_raise = 1'b1;
                        err_val   = ERR_LEN;
                    end else begin
                        len_d   = PTR_W'(bus.i_rx_data);
`ifdef UART_CMD_CHK_EN
                        chk_d   = bus.i_rx_data;
`endif
                        state_d = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (bus.i_rx_done && !err_raise) begin
                    mem_d[wr_ptr_q[IDX_W-1:0]] = bus.i_rx_data;
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
`ifdef UART_CMD_CHK_EN
                    chk_d    = chk_q ^ bus.i_rx_data;
`endif
                    if ((wr_ptr_q + PTR_W'(1)) == len_q) begin
`ifdef UART_CMD_CHK_EN
                        state_d  = ST_CHK;
`else
                        state_d  = ST_CS_LEAD;
                        cs_n_d   = 1'b0;
                        cs_cnt_d = '0;
`endif
                    end
                end
            end
            ST_CHK: begin
`ifdef UART_CMD_CHK_EN
                if (bus.i_rx_done && !err_raise) begin
                    if (bus.i_rx_data == chk_q) begin
                        state_d  = ST_CS_LEAD;
                        cs_n_d   = 1'b0;
                        cs_cnt_d = '0;
                    end else begin
                        err_raise = 1'b1;
                        err_val   = ERR_CHK;
                    end
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_CS_LEAD: begin
                cs_cnt_d = cs_cnt_q + CS_W'(1);
                // Launching the first byte straight from the last lead cycle
                // keeps cs_n-fall to first start at exactly CS_SETUP cycles.
                if (cs_cnt_done) begin
                    if (!bus.i_spi_busy) begin
                        issue_send = 1'b1;
                    end else begin
                        state_d = ST_SEND;
                    end
                end
            end
            ST_SEND: begin
                if (!bus.i_spi_busy) begin
                    issue_send = 1'b1;
                end
            end
            ST_WAIT: begin
                if (bus.i_spi_done) begin
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                    if ((rd_ptr_q + PTR_W'(1)) == len_q) begin
                        state_d  = ST_CS_TRAIL;
                        cs_cnt_d = '0;
                    end else begin
                        state_d = ST_SEND;
                    end
                end
            end
            ST_CS_TRAIL: begin
                cs_cnt_d = cs_cnt_q + CS_W'(1);
                if (cs_cnt_done) begin
                    cs_n_d     = 1'b1;
                    frame_ok_d = 1'b1;
                    wr_ptr_d   = '0;
                    rd_ptr_d   = '0;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (issue_send) begin
            spi_data_d  = mem_q[rd_ptr_q[IDX_W-1:0]];
            spi_start_d = 1'b1;
            state_d     = ST_WAIT;
        end

        if (err_raise) begin
            frame_err_d = 1'b1;
            err_code_d  = err_val;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            state_d     = ST_IDLE;
        end
    end

    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            tmo_q       <= '0;
            cs_cnt_q    <= '0;
            cs_n_q      <= 1'b1;
            spi_start_q <= 1'b0;
            spi_data_q  <= '0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_code_q  <= '0;
            overrun_q   <= 1'b0;
            for (int unsigned i = 0; i < MAX_LEN; i++) begin
                mem_q[i] <= '0;
            end
`ifdef UART_CMD_CHK_EN
            chk_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            tmo_q       <= tmo_d;
            cs_cnt_q    <= cs_cnt_d;
            cs_n_q      <= cs_n_d;
            spi_start_q <= spi_start_d;
            spi_data_q  <= spi_data_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
            err_code_q  <= err_code_d;
            overrun_q   <= overrun_d;
            mem_q       <= mem_d;
`ifdef UART_CMD_CHK_EN
            chk_q       <= chk_d;
`endif
        end
    end

    assign bus.o_spi_cs_n  = cs_n_q;
    assign bus.o_spi_start = spi_start_q;
    assign bus.o_spi_data  = spi_data_q;
    assign bus.o_busy      = (state_q != ST_IDLE);
    assign bus.o_frame_ok  = frame_ok_q;
    assign bus.o_frame_err = frame_err_q;
    assign bus.o_err_code  = err_code_q;
    assign bus.o_overrun   = overrun_q;
endmodule

// File: tb/tb_uart_spi_cmd_sched.sv
// tb_uart_spi_cmd_sched
//   Self-checking bench for uart_spi_cmd_sched. Frame vectors live in a
//   table; expected SPI bytes go into a queue when a good frame is driven
//   and are popped when the scheduler pulses o_spi_start. Works with and
//   without UART_CMD_CHK_EN (checksum byte appended only when defined).
module tb_uart_spi_cmd_sched;
    localparam int MAX_LEN_T  = 16;
    localparam int TMO_T      = 60;
    localparam int CS_SETUP_T = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_spi_cmd_sched_if #(.DATA_WIDTH(8)) bus ();

    uart_spi_cmd_sched #(
        .DATA_WIDTH (8),
        .MAX_LEN    (MAX_LEN_T),
        .HEADER     (8'hA5),
        .TIMEOUT_CYC(TMO_T),
        .CS_SETUP   (CS_SETUP_T)
    ) dut (
        .i_clk_sys(clk),
        .i_rst_n  (rst_n),
        .bus      (bus)
    );

    typedef struct {
        int         pre;       // junk byte before header, -1 for none
        logic [7:0] len;
        int         npay;      // payload bytes actually driven
        logic [7:0] pay [16];
        int         bad_par;   // -1 none, 0 LEN byte, k payload byte k-1
        logic [7:0] chk_xor;   // nonzero corrupts the checksum byte
        int         exp_code;  // 0 frame passes, else expected error code
    } vec_t;

    vec_t       vecs [$];
    logic [7:0] exp_q [$];
    int checks = 0;
    int errors = 0;
    int n_start = 0, n_ok = 0, n_err = 0, n_ovr = 0;
    int done_cyc = 0;
    logic [1:0] exp_err = 2'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // SPI master model: busy for a few cycles after each start, then done.
    task automatic spi_model();
        forever begin
            @(negedge clk);
            if (bus.o_spi_start === 1'b1) begin
                bus.i_spi_busy = 1'b1;
                repeat (3) @(negedge clk);
                bus.i_spi_done = 1'b1;
                done_cyc = cyc;
                @(negedge clk);
                bus.i_spi_done = 1'b0;
                bus.i_spi_busy = 1'b0;
            end
        end
    endtask

    task automatic monitor();
        logic prev_cs;
        int   fall_cyc;
        bit   lead_pending;
        prev_cs = 1'b1;
        fall_cyc = 0;
        lead_pending = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_cs && !bus.o_spi_cs_n) begin
                fall_cyc = cyc;
                lead_pending = 1'b1;
            end
            prev_cs = bus.o_spi_cs_n;
            if (bus.o_spi_start === 1'b1) begin
                n_start++;
                check("start_cs_low", 32'(bus.o_spi_cs_n), 32'd0);
                if (lead_pending) begin
                    check("cs_lead_gap", 32'(cyc - fall_cyc), 32'(CS_SETUP_T));
                    lead_pending = 1'b0;
                end
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spi_data: got unexpected start data %0h expected none", bus.o_spi_data);
                end else begin
                    check("spi_data", 32'(bus.o_spi_data), 32'(exp_q.pop_front()));
                end
            end
            if (bus.o_frame_ok === 1'b1) begin
                n_ok++;
                check("cs_trail_gap", 32'(cyc - done_cyc), 32'(CS_SETUP_T + 1));
                check("cs_high_at_ok", 32'(bus.o_spi_cs_n), 32'd1);
            end
            if (bus.o_frame_err === 1'b1) n_err++;
            if (bus.o_overrun === 1'b1) n_ovr++;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit par_ok);
        @(negedge clk);
        bus.i_rx_data      = b;
        bus.i_rx_parity_ok = par_ok;
        bus.i_rx_done      = 1'b1;
        @(negedge clk);
        bus.i_rx_done      = 1'b0;
        bus.i_rx_parity_ok = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (!bus.o_busy) break;
        end
        @(negedge clk);
        check(name, 32'(bus.o_busy), 32'd0);
    endtask

    task automatic wait_start(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.o_spi_start === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check(name, 32'(seen), 32'd1);
    endtask

    function automatic vec_t mk(input int pre, input int len, input int npay, input int p0,
                                input int p1, input int bad_par, input int chk_xor, input int exp_code);
        vec_t v;
        v.pre = pre;
        v.len = 8'(len);
        v.npay = npay;
        for (int i = 0; i < 16; i++) v.pay[i] = 8'h00;
        v.pay[0] = 8'(p0);
        v.pay[1] = 8'(p1);
        v.bad_par = bad_par;
        v.chk_xor = 8'(chk_xor);
        v.exp_code = exp_code;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        int ok0, err0, st0;
        logic [7:0] chk;
        bit stop;
        ok0 = n_ok;
        err0 = n_err;
        st0 = n_start;
        chk = v.len;
        stop = 1'b0;
        for (int i = 0; i < v.npay; i++) chk = chk ^ v.pay[i];
        if (v.exp_code == 0) begin
            for (int i = 0; i < v.npay; i++) exp_q.push_back(v.pay[i]);
        end
        if (v.pre >= 0) send_byte(8'(v.pre), 1'b1);
        send_byte(8'hA5, 1'b1);
        send_byte(v.len, v.bad_par != 0);
        if (v.bad_par == 0) stop = 1'b1;
        for (int i = 0; i < v.npay && !stop; i++) begin
            send_byte(v.pay[i], v.bad_par != i + 1);
            if (v.bad_par == i + 1) stop = 1'b1;
        end
`ifdef UART_CMD_CHK_EN
        if (!stop && v.exp_code != 2) send_byte(chk ^ v.chk_xor, 1'b1);
`endif
        wait_idle($sformatf("v%0d_idle", idx));
        if (v.exp_code != 0) exp_err = 2'(v.exp_code);
        check($sformatf("v%0d_frame_ok", idx), 32'(n_ok - ok0), (v.exp_code == 0) ? 32'd1 : 32'd0);
        check($sformatf("v%0d_frame_err", idx), 32'(n_err - err0), (v.exp_code == 0) ? 32'd0 : 32'd1);
        check($sformatf("v%0d_err_code", idx), 32'(bus.o_err_code), 32'(exp_err));
        check($sformatf("v%0d_starts", idx), 32'(n_start - st0), (v.exp_code == 0) ? 32'(v.npay) : 32'd0);
        check($sformatf("v%0d_cs_n", idx), 32'(bus.o_spi_cs_n), 32'd1);
    endtask

    initial begin
        vec_t v;
        int ok0, err0, st0, ov0;

        rst_n              = 1'b0;
        bus.i_rx_data      = 8'h00;
        bus.i_rx_done      = 1'b0;
        bus.i_rx_parity_ok = 1'b1;
        bus.i_spi_busy     = 1'b0;
        bus.i_spi_done     = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_cs_n",      32'(bus.o_spi_cs_n),  32'd1);
        check("rst_start",     32'(bus.o_spi_start), 32'd0);
        check("rst_data",      32'(bus.o_spi_data),  32'd0);
        check("rst_busy",      32'(bus.o_busy),      32'd0);
        check("rst_frame_ok",  32'(bus.o_frame_ok),  32'd0);
        check("rst_frame_err", 32'(bus.o_frame_err), 32'd0);
        check("rst_err_code",  32'(bus.o_err_code),  32'd0);
        check("rst_overrun",   32'(bus.o_overrun),   32'd0);

        rst_n = 1'b1;
        fork
            monitor();
            spi_model();
        join_none

        vecs.push_back(mk(-1, 2, 2, 'h3C, 'h7E, -1, 0, 0));
`ifdef UART_CMD_CHK_EN
        vecs.push_back(mk(-1, 2, 2, 'h3C, 'h7E, -1, 1, 3));
`endif
        vecs.push_back(mk(-1, 0,  0, 0, 0, -1, 0, 2));
        vecs.push_back(mk(-1, 17, 0, 0, 0, -1, 0, 2));
        vecs.push_back(mk(-1, 1, 1, 'h9A, 0, -1, 0, 0));
        vecs.push_back(mk(-1, 2, 2, 'h3C, 'h7E, 1, 0, 3));
        vecs.push_back(mk('h55, 1, 1, 'h10, 0, -1, 0, 0));
        v = mk(-1, MAX_LEN_T, MAX_LEN_T, 0, 0, -1, 0, 0);
        for (int i = 0; i < MAX_LEN_T; i++) v.pay[i] = 8'(i * 7 + 1);
        vecs.push_back(v);
        vecs.push_back(mk(-1, 2, 2, 'h3C, 'h7E, 0, 0, 3));

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Inter-byte timeout mid-payload.
        err0 = n_err;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h11, 1'b1);
        repeat (TMO_T - 10) @(negedge clk);
        check("tmo_busy_early", 32'(bus.o_busy), 32'd1);
        check("tmo_no_err_early", 32'(n_err - err0), 32'd0);
        wait_idle("tmo_idle");
        exp_err = 2'd1;
        check("tmo_frame_err", 32'(n_err - err0), 32'd1);
        check("tmo_err_code", 32'(bus.o_err_code), 32'd1);

        // Byte arriving during the SPI transfer is dropped.
        ok0 = n_ok;
        ov0 = n_ovr;
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h33);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
`ifdef UART_CMD_CHK_EN
        send_byte(8'h03, 1'b1);
`endif
        wait_start("ovr_start_seen");
        send_byte(8'h55, 1'b1);
        wait_idle("ovr_idle");
        check("ovr_pulses", 32'(n_ovr - ov0), 32'd1);
        check("ovr_frame_ok", 32'(n_ok - ok0), 32'd1);
        check("ovr_err_code", 32'(bus.o_err_code), 32'(exp_err));
        check("ovr_sb_empty", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset while waiting for the SPI master.
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'hBB);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
`ifdef UART_CMD_CHK_EN
        send_byte(8'h02 ^ 8'hAA ^ 8'hBB, 1'b1);
`endif
        wait_start("rst_start_seen");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rstw_cs_n", 32'(bus.o_spi_cs_n), 32'd1);
        check("rstw_busy", 32'(bus.o_busy), 32'd0);
        check("rstw_start", 32'(bus.o_spi_start), 32'd0);
        exp_q.delete();
        exp_err = 2'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("rstw_busy_after_done", 32'(bus.o_busy), 32'd0);
        check("rstw_err_code", 32'(bus.o_err_code), 32'd0);

        // Single-byte frame after reset.
        ok0 = n_ok;
        st0 = n_start;
        exp_q.push_back(8'h9A);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h9A, 1'b1);
`ifdef UART_CMD_CHK_EN
        send_byte(8'h9B, 1'b1);
`endif
        wait_idle("single_idle");
        check("single_starts", 32'(n_start - st0), 32'd1);
        check("single_frame_ok", 32'(n_ok - ok0), 32'd1);
        check("final_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
